lsu_mem_access: RTL
===================

Name: lsu_mem_access

Overview:
- Memory-access stage of the LSU, directly downstream of the LSU execute stage.
- Accepts the execute stage's effective-address read/write request and drives a req/gnt/rvalid data-memory port.
- Stalls upstream while a transaction is outstanding.
- For loads, it aligns and sign- or zero-extends the returned data, then presents it to writeback with the destination register index.

Parameters:
- MAX_WAIT, 255: cycle limit for a transaction in REQ+WAIT states before bus error. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents a request this cycle.
- ex_ready  out  1  stage can accept. High only in IDLE.
- rd_addr  in  32  load byte address.
- rd_en  in  1  load request.
- rd_size  in  2  load size: 00 byte, 01 half, 10 word, 11 illegal.
- wr_addr  in  32  store byte address.
- wr_data  in  32  store data, right-justified.
- wr_en  in  1  store request.
- wr_size  in  2  store size, same encoding as rd_size.
- load_unsigned  in  1  1 = zero-extend, 0 = sign-extend load data.
- rd_idx  in  5  destination register of the load.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address: {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_rd_idx  out  5  destination register.
- wb_data  out  32  extended load result.
- misaligned  out  1  one-cycle pulse: request rejected for alignment or illegal size.
- bus_error  out  1  one-cycle pulse: timeout.

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE and all captured registers clear.
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_valid, wb_rd_idx, wb_data, misaligned and bus_error are 0.
  - ex_ready is 1.
  - Reset mid-transaction abandons it: mem_req drops immediately and no wb_valid is produced.
- States: IDLE, REQ, WAIT.
- IDLE, on ex_valid (accept on clock edge):
  - rd_en set: the request is a load. If wr_en is also set, the store is ignored.
  - Only wr_en set: the request is a store.
  - Neither set (NOP): consumed, no action.
  - Legal access: latch the request and go to REQ.
  - Illegal access: misaligned pulses in the next cycle, no memory access, stay in IDLE.
  - Illegal cases: size 11; half with addr[0]=1; word with addr[1:0]≠0.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are registered and held stable until mem_gnt.
  - On mem_gnt, a store returns to IDLE and a load goes to WAIT.
- WAIT:
  - mem_req=0.
  - On mem_rvalid, capture, extract and extend the data, register wb_valid/wb_data/wb_rd_idx, and go to IDLE.
  - mem_rvalid is never sampled in the cycle of mem_gnt; it is ignored in any state other than WAIT.
- Byte enables:
  - byte: 4'b0001 << a[1:0].
  - half: 4'b0011 << a[1:0].
  - word: 4'b1111.
- Store data:
  - byte: {4{wr_data[7:0]}}.
  - half: {2{wr_data[15:0]}}.
  - word: as is.
- Load extraction:
  - shift mem_rdata right by 8*a[1:0].
  - Take the low 8, 16 or 32 bits.
  - Extend to 32 bits per load_unsigned.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches MAX_WAIT (MAX_WAIT≠0) without completion: bus_error pulses in the next cycle, mem_req drops, state goes to IDLE, no wb_valid.
  - Completion in the same cycle as the limit counts as success.
- Latency:
  - Accept at edge 0; mem_req high from cycle 1.
  - Zero-wait gnt: the store finishes at edge 1 and ex_ready is high in cycle 2.
  - Load with rvalid in cycle 2: wb_valid is high in cycle 3.
  - Throughput is one transaction at a time; no pipelining of requests.

Test Plan:
- Byte store: wr_addr=0x1003, wr_data=0xAB, size 00, gnt immediate -> mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1; ex_ready low for exactly 1 cycle.
- Signed half load: rd_addr=0x2002, load_unsigned=0, rdata=0x80F51234 -> wb_data=0xFFFF80F5, wb_rd_idx matches. Repeat with load_unsigned=1 -> 0x000080F5.
- Misaligned word: rd_addr=0x3001 -> misaligned pulse 1 cycle, mem_req never asserted, no wb_valid. Size 11 gives the same response.
- Grant stall: mem_gnt delayed 4 cycles -> mem_req and all mem_* outputs stable for 5 cycles; ex_ready low throughout; new ex_valid requests not accepted.
- Timeout: MAX_WAIT=8, load granted but rvalid never arrives -> bus_error pulse, return to IDLE, no wb_valid, next request serviced normally.
- Reset in WAIT: assert rst_n=0 mid-load -> mem_req and all outputs 0 immediately; after release, a late rvalid is ignored.

Source files
------------

// File: rtl/lsu_mem_access.sv
// Purpose : LSU memory-access stage; turns an execute-stage load/store into one req/gnt/rvalid transaction and returns extended load data.
// Latency : accept at edge 0, mem_req from cycle 1; zero-wait store frees the stage in cycle 2, load with rvalid in cycle 2 gives wb_valid in cycle 3.
// Backpressure: ex_ready is high only in IDLE; a transaction holds the stage until gnt (store), rvalid (load) or timeout.
//
// Ports:
//   clk, rst_n                      clock and async active-low reset
//   ex_valid / ex_ready             execute-stage handshake
//   rd_addr, rd_en, rd_size         load request (size 00 byte, 01 half, 10 word)
//   wr_addr, wr_data, wr_en, wr_size store request; a load wins when both are set
//   load_unsigned, rd_idx           extension mode and destination register
//   mem_req/we/addr/be/wdata        data-memory request, held stable until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata  data-memory response
//   wb_valid, wb_rd_idx, wb_data    one-cycle load writeback
//   misaligned, bus_error           one-cycle error pulses
module lsu_mem_access #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] rd_addr,
    input  logic        rd_en,
    input  logic [1:0]  rd_size,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic [1:0]  wr_size,
    input  logic        load_unsigned,
    input  logic [4:0]  rd_idx,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_idx,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        bus_error
);

    // Counter only needs to reach MAX_WAIT; a disabled timeout keeps a 1-bit dummy.
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [1:0]  ld_off;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic [4:0]  ld_idx;

    logic        req_load;
    logic        req_any;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_illegal;
    logic [3:0]  req_be;
    logic [31:0] st_data;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;
    logic        timeout;

    always_comb begin
        req_load = rd_en;
        req_any  = rd_en | wr_en;
        req_addr = rd_en ? rd_addr : wr_addr;
        req_size = rd_en ? rd_size : wr_size;

        case (req_size)
            2'b00: begin
                req_illegal = 1'b0;
                req_be      = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                req_illegal = req_addr[0];
                req_be      = 4'b0011 << req_addr[1:0];
            end
            2'b10: begin
                req_illegal = |req_addr[1:0];
                req_be      = 4'b1111;
            end
            default: begin
                req_illegal = 1'b1;
                req_be      = 4'b0000;
            end
        endcase

        // Replicate so the memory can pick the lane selected by mem_be.
        case (wr_size)
            2'b00:   st_data = {4{wr_data[7:0]}};
            2'b01:   st_data = {2{wr_data[15:0]}};
            default: st_data = wr_data;
        endcase

        ld_shift = mem_rdata >> {ld_off, 3'b000};
        case (ld_size)
            2'b00:   ld_ext = {{24{ld_shift[7]  & ~ld_unsigned}}, ld_shift[7:0]};
            2'b01:   ld_ext = {{16{ld_shift[15] & ~ld_unsigned}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // Completion is tested before timeout, so a response in the limit cycle still succeeds.
    assign timeout  = (MAX_WAIT != 0) && (cnt == CW'(MAX_WAIT));
    assign ex_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            ld_off      <= 2'b00;
            ld_size     <= 2'b00;
            ld_unsigned <= 1'b0;
            ld_idx      <= 5'd0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_be      <= 4'd0;
            mem_wdata   <= 32'd0;
            wb_valid    <= 1'b0;
            wb_rd_idx   <= 5'd0;
            wb_data     <= 32'd0;
            misaligned  <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A NOP (neither enable) is consumed without any effect.
                    if (ex_valid && req_any) begin
                        if (req_illegal) begin
                            misaligned <= 1'b1;
                        end else begin
                            state       <= ST_REQ;
                            cnt         <= '0;
                            mem_req     <= 1'b1;
                            mem_we      <= ~req_load;
                            mem_addr    <= {req_addr[31:2], 2'b00};
                            mem_be      <= req_be;
                            mem_wdata   <= req_load ? 32'd0 : st_data;
                            ld_off      <= req_addr[1:0];
                            ld_size     <= req_size;
                            ld_unsigned <= load_unsigned;
                            ld_idx      <= rd_idx;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + CW'(1);
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_we ? ST_IDLE : ST_WAIT;
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (mem_rvalid) begin
                        wb_valid  <= 1'b1;
                        wb_data   <= ld_ext;
                        wb_rd_idx <= ld_idx;
                        state     <= ST_IDLE;
                    end else if (timeout) begin
                        bus_error <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
